// File: rtl/casez_sweep_driver.sv
// Sweep driver for the casez decoder stage: walks the 3-bit selector through all
// eight values and scores each one. Define CASEZ_SWEEP_XCHECK_EN to also score out3/out5.
module casez_sweep_driver #(
    parameter int size   = 1,
    parameter int settle = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic [size-1:0] src1,
    output logic [size-1:0] src2,
    output logic [size-1:0] src3,
    input  logic [size-1:0] out1,
    input  logic [size-1:0] out2,
    input  logic [size-1:0] out3,
    input  logic [size-1:0] out4,
    input  logic [size-1:0] out5,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_vec,
    output logic [3:0]      err_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(settle);

    state_t          state_q, state_d;
    logic [2:0]      vec_q, vec_d;
    logic [3:0]      hold_q, hold_d;
    logic [size-1:0] src1_q, src1_d;
    logic [size-1:0] src2_q, src2_d;
    logic [size-1:0] src3_q, src3_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [7:0]      err_vec_q, err_vec_d;
    logic [3:0]      err_count_q, err_count_d;
    logic            vec_fail;

    // Zero-extend or truncate a 3-bit reference value to the data width.
    function automatic logic [size-1:0] fit3(input logic [2:0] val);
        logic [7:0] wide;
        wide = {5'b0, val};
        return wide[size-1:0];
    endfunction

    function automatic logic [size-1:0] drive_bit(input logic b);
        logic [7:0] wide;
        wide = {7'b0, b};
        return wide[size-1:0];
    endfunction

    function automatic logic [2:0] prio_exp(input logic [2:0] v);
        logic [2:0] r;
        if (v[2])      r = 3'd0;
        else if (v[1]) r = 3'd1;
        else if (v[0]) r = 3'd2;
        else           r = 3'd3;
        return r;
    endfunction

    // An unknown operand makes the if-condition false, so x/z lands as a mismatch.
    function automatic logic differs(input logic [size-1:0] act, input logic [size-1:0] exp);
        logic m;
        m = 1'b1;
        if (act == exp) m = 1'b0;
        return m;
    endfunction

    always_comb begin
        vec_fail = 1'b0;
        if (differs(out1, fit3(vec_q)))           vec_fail = 1'b1;
        if (differs(out2, fit3(prio_exp(vec_q)))) vec_fail = 1'b1;
        if (differs(out4, fit3(prio_exp(vec_q)))) vec_fail = 1'b1;
`ifdef CASEZ_SWEEP_XCHECK_EN
        // Only rows the decoder defines for known inputs; the rest default to x.
        if (vec_q == 3'd0 && differs(out3, fit3(3'd3))) vec_fail = 1'b1;
        if (vec_q == 3'd1 && differs(out3, fit3(3'd2))) vec_fail = 1'b1;
        if (vec_q == 3'd1 && differs(out5, fit3(3'd1))) vec_fail = 1'b1;
        if (vec_q == 3'd2 && differs(out5, fit3(3'd2))) vec_fail = 1'b1;
        if (vec_q == 3'd4 && differs(out5, fit3(3'd3))) vec_fail = 1'b1;
`endif
    end

`ifndef CASEZ_SWEEP_XCHECK_EN
    logic xcheck_unused;
    assign xcheck_unused = ^{out3, out5};
`endif

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        hold_d      = hold_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        src3_d      = src3_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_vec_d   = err_vec_q;
        err_count_d = err_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_HOLD;
                    vec_d       = 3'd0;
                    hold_d      = 4'd0;
                    src1_d      = '0;
                    src2_d      = '0;
                    src3_d      = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    err_vec_d   = 8'h00;
                    err_count_d = 4'd0;
                end
            end
            S_HOLD: begin
                if (hold_q < SETTLE_C) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    if (vec_fail) begin
                        err_vec_d   = err_vec_q | (8'b1 << vec_q);
                        err_count_d = err_count_q + 4'd1;
                    end
                    if (vec_q != 3'd7) begin
                        vec_d  = vec_q + 3'd1;
                        hold_d = 4'd0;
                        src1_d = drive_bit(vec_d[2]);
                        src2_d = drive_bit(vec_d[1]);
                        src3_d = drive_bit(vec_d[0]);
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        pass_d = done_d & (err_vec_d == 8'h00);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            vec_q       <= 3'd0;
            hold_q      <= 4'd0;
            src1_q      <= '0;
            src2_q      <= '0;
            src3_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_vec_q   <= 8'h00;
            err_count_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            hold_q      <= hold_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            src3_q      <= src3_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_vec_q   <= err_vec_d;
            err_count_q <= err_count_d;
        end
    end

    assign src1      = src1_q;
    assign src2      = src2_q;
    assign src3      = src3_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_vec   = err_vec_q;
    assign err_count = err_count_q;

endmodule
